// File: rtl/hazard_stall_ctrl.sv
// RAW interlock for the 5-stage pipeline (no forwarding): scoreboard of
// in-flight destinations, stall/flush control, statistics, stall watchdog.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   id_rs/id_rt       ID source registers, qualified by id_use_rs/id_use_rt
//   id_rw             ID destination register, qualified by id_regwrite
//   br_taken_mem      taken branch resolved in MEM
//   pc_en, ifid_en    PC and IF/ID load enables
//   ifid_flush        IF/ID loads a NOP
//   idex_flush        ID/EX loads a bubble
//   exmem_flush       EX/MEM loads a bubble
//   state             action of the previous cycle (0 RUN, 1 STALL, 2 FLUSH)
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of taken-branch flushes
//   err               sticky: stall ran longer than MAX_STALL cycles
module hazard_stall_ctrl #(
   parameter bit WB_BYPASS = 1'b1,
   parameter int MAX_STALL = 3,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       id_rw,
   input  logic             id_regwrite,
   input  logic             br_taken_mem,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             err
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam int RW = $clog2(MAX_STALL + 2);
   localparam logic [RW-1:0]    RUN_MAX = RW'(MAX_STALL);
   localparam logic [RW-1:0]    RUN_ONE = RW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic          ex_v, mem_v, wb_v;
   logic [4:0]    ex_rd, mem_rd, wb_rd;
   state_t        st;
   state_t        act;
   logic [RW-1:0] run_cnt;
   logic          rs_hit, rt_hit, hazard;

   // Slots only ever hold valid=1 with rd!=0, but r0 is still
   // excluded explicitly on the source side.
   assign rs_hit = id_use_rs && (id_rs != 5'd0) &&
                   ((ex_v && ex_rd == id_rs) ||
                    (mem_v && mem_rd == id_rs) ||
                    (!WB_BYPASS && wb_v && wb_rd == id_rs));

   assign rt_hit = id_use_rt && (id_rt != 5'd0) &&
                   ((ex_v && ex_rd == id_rt) ||
                    (mem_v && mem_rd == id_rt) ||
                    (!WB_BYPASS && wb_v && wb_rd == id_rt));

   assign hazard = rs_hit || rt_hit;

   // A taken branch squashes the ID instruction, so its hazard is moot.
   always_comb begin
      act = S_RUN;
      if (br_taken_mem)
         act = S_FLUSH;
      else if (hazard)
         act = S_STALL;
   end

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (!rst_n) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         unique case (act)
            S_FLUSH: begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end
            S_STALL: begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_v      <= 1'b0;
         ex_rd     <= '0;
         mem_v     <= 1'b0;
         mem_rd    <= '0;
         wb_v      <= 1'b0;
         wb_rd     <= '0;
         st        <= S_RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
         err       <= 1'b0;
         run_cnt   <= '0;
      end else begin
         wb_v  <= mem_v;
         wb_rd <= mem_rd;
         unique case (act)
            S_FLUSH: begin
               mem_v   <= 1'b0;
               mem_rd  <= '0;
               ex_v    <= 1'b0;
               ex_rd   <= '0;
               st      <= S_FLUSH;
               run_cnt <= '0;
               if (flush_cnt != '1)
                  flush_cnt <= flush_cnt + CNT_ONE;
            end
            S_STALL: begin
               mem_v  <= ex_v;
               mem_rd <= ex_rd;
               ex_v   <= 1'b0;
               ex_rd  <= '0;
               st     <= S_STALL;
               if (stall_cnt != '1)
                  stall_cnt <= stall_cnt + CNT_ONE;
               // Counter parks at MAX_STALL; any further stall is a fault.
               if (run_cnt == RUN_MAX)
                  err <= 1'b1;
               else
                  run_cnt <= run_cnt + RUN_ONE;
            end
            default: begin
               mem_v   <= ex_v;
               mem_rd  <= ex_rd;
               ex_v    <= id_regwrite && (id_rw != 5'd0);
               ex_rd   <= id_rw;
               st      <= S_RUN;
               run_cnt <= '0;
            end
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances share stimulus
// (0: bypass, MAX 3; 1: no bypass, MAX 3; 2: bypass, MAX 1 for the watchdog).
module tb_hazard_stall_ctrl;

   localparam int CNT_W = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, id_rw;
   logic       id_use_rs, id_use_rt, id_regwrite, br_taken_mem;

   logic             pc_en[3], ifid_en[3], ifid_flush[3];
   logic             idex_flush[3], exmem_flush[3], err[3];
   logic [1:0]       state[3];
   logic [CNT_W-1:0] stall_cnt[3], flush_cnt[3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_stall_ctrl #(
         .WB_BYPASS (g != 1),
         .MAX_STALL (g == 2 ? 1 : 3),
         .CNT_W     (CNT_W)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .id_rs        (id_rs),
         .id_rt        (id_rt),
         .id_use_rs    (id_use_rs),
         .id_use_rt    (id_use_rt),
         .id_rw        (id_rw),
         .id_regwrite  (id_regwrite),
         .br_taken_mem (br_taken_mem),
         .pc_en        (pc_en[g]),
         .ifid_en      (ifid_en[g]),
         .ifid_flush   (ifid_flush[g]),
         .idex_flush   (idex_flush[g]),
         .exmem_flush  (exmem_flush[g]),
         .state        (state[g]),
         .stall_cnt    (stall_cnt[g]),
         .flush_cnt    (flush_cnt[g]),
         .err          (err[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rw, input logic wr,
                        input logic br);
      id_rs        = rs;
      id_use_rs    = urs;
      id_rt        = rt;
      id_use_rt    = urt;
      id_rw        = rw;
      id_regwrite  = wr;
      br_taken_mem = br;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   // Independent instruction stream: writers $1,$2,$4, readers $6,$7.
   logic [4:0] ind_rs[5] = '{5'd8, 5'd9, 5'd10, 5'd6, 5'd7};
   logic [4:0] ind_rw[5] = '{5'd1, 5'd2, 5'd4, 5'd0, 5'd0};
   logic       ind_wr[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst_pc_en", pc_en[0], 0);
      chk("rst_ifid_en", ifid_en[0], 0);
      chk("rst_flushes", {ifid_flush[0], idex_flush[0], exmem_flush[0]}, 3'b111);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_state", state[0], 0);
      chk("rst_stall_cnt", stall_cnt[0], 0);
      chk("rst_flush_cnt", flush_cnt[0], 0);
      chk("rst_err", err[0], 0);
      chk("rst_run_pc_en", pc_en[0], 1);

      // Back-to-back dependency on $3.
      drive(0, 0, 0, 0, 3, 1, 0);
      chk("dep_c0_pc_en", pc_en[0], 1);
      tick();
      drive(3, 1, 0, 0, 0, 0, 0);
      chk("dep_c1_pc_en", pc_en[0], 0);
      chk("dep_c1_idex_flush", idex_flush[0], 1);
      chk("dep_c1_ifid_flush", ifid_flush[0], 0);
      chk("dep_c1_ifid_en", ifid_en[0], 0);
      chk("dep_c1_state", state[0], 0);
      chk("dep_c1_nb_pc_en", pc_en[1], 0);
      tick();
      chk("dep_c2_pc_en", pc_en[0], 0);
      chk("dep_c2_state", state[0], 1);
      tick();
      chk("dep_c3_pc_en", pc_en[0], 1);
      chk("dep_c3_state", state[0], 1);
      chk("dep_c3_nb_pc_en", pc_en[1], 0);
      tick();
      chk("dep_c4_state", state[0], 0);
      chk("dep_c4_pc_en", pc_en[0], 1);
      chk("dep_stall_cnt", stall_cnt[0], 2);
      chk("dep_nb_pc_en", pc_en[1], 1);
      chk("dep_nb_state", state[1], 1);
      chk("dep_nb_stall_cnt", stall_cnt[1], 3);
      chk("dep_err", err[0], 0);
      chk("dep_nb_err", err[1], 0);
      chk("wd_err_set", err[2], 1);
      tick();
      chk("wd_err_hold", err[2], 1);
      chk("dep_nb_state_run", state[1], 0);
      do_reset();
      chk("wd_err_clr", err[2], 0);

      // rt-side dependency.
      drive(0, 0, 0, 0, 12, 1, 0);
      tick();
      drive(12, 0, 12, 1, 0, 0, 0);
      chk("rt_dep_pc_en", pc_en[0], 0);
      do_reset();

      // r0 never interlocks.
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      drive(0, 1, 0, 1, 0, 0, 0);
      chk("r0_pc_en", pc_en[0], 1);
      chk("r0_nb_pc_en", pc_en[1], 1);
      tick();
      chk("r0_stall_cnt", stall_cnt[0], 0);
      do_reset();

      // Taken branch while $5 hazard is pending.
      drive(0, 0, 0, 0, 5, 1, 0);
      tick();
      drive(5, 1, 0, 0, 0, 0, 1);
      chk("br_pc_en", pc_en[0], 1);
      chk("br_ifid_en", ifid_en[0], 1);
      chk("br_flushes", {ifid_flush[0], idex_flush[0], exmem_flush[0]}, 3'b111);
      tick();
      drive(5, 1, 0, 0, 0, 0, 0);
      chk("br_state", state[0], 2);
      chk("br_flush_cnt", flush_cnt[0], 1);
      chk("br_stall_cnt", stall_cnt[0], 0);
      chk("br_next_pc_en", pc_en[0], 1);
      chk("br_next_nb_pc_en", pc_en[1], 1);
      tick();
      chk("br_state_run", state[0], 0);
      do_reset();

      // Independent stream: never stalls.
      for (int i = 0; i < 5; i++) begin
         drive(ind_rs[i], 1, 5'd11, 1, ind_rw[i], ind_wr[i], 0);
         chk($sformatf("ind_pc_en_%0d", i), pc_en[0], 1);
         tick();
      end
      chk("ind_stall_cnt", stall_cnt[0], 0);
      do_reset();

      // Reset during the second stall cycle.
      drive(0, 0, 0, 0, 3, 1, 0);
      tick();
      drive(3, 1, 0, 0, 0, 0, 0);
      tick();
      chk("rms_stall2", pc_en[0], 0);
      rst_n = 1'b0;
      #1;
      chk("rms_pc_en", pc_en[0], 0);
      chk("rms_flushes", {ifid_flush[0], idex_flush[0], exmem_flush[0]}, 3'b111);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rms_state", state[0], 0);
      chk("rms_stall_cnt", stall_cnt[0], 0);
      chk("rms_after_pc_en", pc_en[0], 1);
      chk("rms_nb_pc_en", pc_en[1], 1);
      tick();
      chk("rms_state_run", state[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
